fifo_read_packer: RTL and testbench

- Consumer-side engine for the FIFO read port. It drives read_en and samples data on the valid handshake.
- Packs PACK consecutive DATA_W-bit words into one wide word.
- Presents the wide word downstream on an out_valid/out_ready handshake.
- Sits between the FIFO (controller plus buffer) read side and the wide-datapath consumer.

---
 rtl/fifo_read_packer.sv | 129 ++++++++++++
 tb/tb_fifo_read_packer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_packer.sv
// ============================================================================
// fifo_read_packer: reads DATA_W words from a FIFO and packs PACK of them into
// one wide word for a ready/valid consumer. Option macro: FLUSH_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_read_packer #(
  parameter int DATA_W  = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       valid,
  input  logic [DATA_W-1:0]          din,
  output logic                       read_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W*PACK-1:0]     dout,
  output logic [$clog2(PACK+1)-1:0]  out_cnt
);

  localparam int CNT_W = $clog2(PACK + 1);

  generate
    if (PACK < 2 || TIMEOUT < 1) begin : g_param_check
      $error("fifo_read_packer: PACK must be >= 2 and TIMEOUT >= 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;
  logic [DATA_W*PACK-1:0]   dout_q, dout_d;
  logic                     out_valid_q, out_valid_d;
  logic                     xfer;

  // Gated by reset so the FIFO is never popped while the packer is held in reset.
  assign read_en   = en & (state_q == FILL) & rst;
  assign xfer      = read_en & valid;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_cnt   = out_cnt_q;

`ifdef FLUSH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_cnt_d   = out_cnt_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
`ifdef FLUSH_TIMEOUT_EN
    idle_d      = '0;
`endif
    case (state_q)
      FILL: begin
        if (xfer) begin
          dout_d[int'(cnt_q)*DATA_W +: DATA_W] = din;
          if (cnt_q == CNT_W'(PACK - 1)) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            out_cnt_d   = CNT_W'(PACK);
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef FLUSH_TIMEOUT_EN
        // A stalled partial group is pushed out once it has sat idle TIMEOUT cycles.
        else if (cnt_q != '0) begin
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            out_cnt_d   = cnt_q;
            cnt_d       = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
`endif
      end
      SEND: begin
        if (out_ready) begin
          state_d     = FILL;
          out_valid_d = 1'b0;
          dout_d      = '0;
          out_cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      out_cnt_q   <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef FLUSH_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_cnt_q   <= out_cnt_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
`ifdef FLUSH_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer with a scoreboard of expected packed words.
`default_nettype none

module tb_fifo_read_packer;

  localparam int DATA_W  = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  din = '0;
  logic        read_en;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] dout;
  logic [2:0]  out_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [34:0] exp_q[$];
  int acc_cyc[$];

  fifo_read_packer #(.DATA_W(DATA_W), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .valid(valid), .din(din),
    .read_en(read_en), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: a packed word is accepted at the next edge when valid&ready here.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {29'd0, out_cnt, dout}, 64'hDEAD);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        chk("sb_dout", 64'(dout), 64'(e[31:0]));
        chk("sb_out_cnt", 64'(out_cnt), 64'(e[34:32]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Hold din/valid until the DUT takes the word.
  task automatic send_word(input logic [7:0] w);
    bit took = 0;
    din = w;
    valid = 1'b1;
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk);
      took = read_en;
      tick();
    end
    if (!took) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset with inputs active
    en = 1'b1; valid = 1'b1; din = 8'h11; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_read_en", 64'(read_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    tick();
    rst = 1'b1;

    // Steady stream, two groups back to back
    exp_q.push_back({3'd4, 32'h44332211});
    exp_q.push_back({3'd4, 32'h88776655});
    for (int i = 1; i <= 8; i++) send_word(8'(i * 8'h11));
    valid = 1'b0;
    drain();
    chk("period", 64'(acc_cyc[1] - acc_cyc[0]), 64'd5);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_word(8'(i * 8'h11));
    valid = 1'b1; din = 8'h99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_read_en", 64'(read_en), 64'd0);
      chk("bp_dout", 64'(dout), 64'h44332211);
      tick();
    end
    exp_q.push_back({3'd4, 32'h44332211});
    out_ready = 1'b1;
    valid = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_resume_read_en", 64'(read_en), 64'd1);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Valid gaps: 1,0,0,1,1,0,1
    exp_q.push_back({3'd4, 32'hA4A3A2A1});
    valid = 1'b1; din = 8'hA1; tick();
    valid = 1'b0; din = 8'hEE; tick();
    tick();
    valid = 1'b1; din = 8'hA2; tick();
    din = 8'hA3; tick();
    valid = 1'b0; din = 8'hEF; tick();
    valid = 1'b1; din = 8'hA4; tick();
    valid = 1'b0;
    drain();

    // en pause mid-group retains partial data
    exp_q.push_back({3'd4, 32'hB4B3B2B1});
    send_word(8'hB1); send_word(8'hB2);
    en = 1'b0; din = 8'hCC;
    repeat (5) tick();
    @(negedge clk);
    chk("pause_read_en", 64'(read_en), 64'd0);
    chk("pause_out_valid", 64'(out_valid), 64'd0);
    tick();
    en = 1'b1;
    send_word(8'hB3); send_word(8'hB4);
    valid = 1'b0;
    drain();

    // Reset mid-group discards partial lanes
    send_word(8'h55); send_word(8'h66);
    valid = 1'b0;
    rst = 1'b0; tick();
    @(negedge clk);
    chk("midrst_dout", 64'(dout), 64'd0);
    chk("midrst_read_en", 64'(read_en), 64'd0);
    tick();
    rst = 1'b1;
    exp_q.push_back({3'd4, 32'h04030201});
    for (int i = 1; i <= 4; i++) send_word(8'(i));
    valid = 1'b0;
    drain();

    // Partial group then idle
    out_ready = 1'b0;
    send_word(8'h0A); send_word(8'h0B); send_word(8'h0C);
    valid = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      if (i < TIMEOUT) chk("idle_out_valid", 64'(out_valid), 64'd0);
    end
`ifdef FLUSH_TIMEOUT_EN
    chk("flush_out_valid", 64'(out_valid), 64'd1);
    exp_q.push_back({3'd3, 32'h000C0B0A});
    out_ready = 1'b1;
    drain();
`else
    chk("noflush_out_valid", 64'(out_valid), 64'd0);
    repeat (20) tick();
    chk("noflush_late_valid", 64'(out_valid), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
